// File: rtl/execute_cycle.sv
// Execute stage: forwarding muxes, ALU, branch decision/target and the execute/memory
// pipeline register with synchronous flush.
module execute_cycle (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteE,
   input  logic        ALUSrcE,
   input  logic        MemWriteE,
   input  logic        ResultSrcE,
   input  logic        BranchE,
   input  logic [2:0]  ALUControlE,
   input  logic [31:0] RD1_E,
   input  logic [31:0] RD2_E,
   input  logic [31:0] Imm_ExtE,
   input  logic [31:0] PCE,
   input  logic [31:0] PCPlus4E,
   input  logic [4:0]  RD_E,
   input  logic [31:0] ResultW,
   input  logic [1:0]  ForwardAE,
   input  logic [1:0]  ForwardBE,
   input  logic        FlushM,
   output logic        PCSrcE,
   output logic [31:0] PCTargetE,
   output logic        RegWriteM,
   output logic        MemWriteM,
   output logic        ResultSrcM,
   output logic [4:0]  RD_M,
   output logic [31:0] ALUResultM,
   output logic [31:0] WriteDataM,
   output logic [31:0] PCPlus4M
);

   logic [31:0] src_a, fwd_b, src_b, alu_result;
   logic        zero;

   logic        reg_write_d, reg_write_q;
   logic        mem_write_d, mem_write_q;
   logic        result_src_d, result_src_q;
   logic [4:0]  rd_d, rd_q;
   logic [31:0] alu_result_d, alu_result_q;
   logic [31:0] write_data_d, write_data_q;
   logic [31:0] pc_plus4_d, pc_plus4_q;

   // Select 10 forwards the registered result, so there is no loop through the ALU.
   always_comb begin
      src_a = RD1_E;
      case (ForwardAE)
         2'b01:   src_a = ResultW;
         2'b10:   src_a = alu_result_q;
         default: src_a = RD1_E;
      endcase
      fwd_b = RD2_E;
      case (ForwardBE)
         2'b01:   fwd_b = ResultW;
         2'b10:   fwd_b = alu_result_q;
         default: fwd_b = RD2_E;
      endcase
      src_b = ALUSrcE ? Imm_ExtE : fwd_b;
   end

   always_comb begin
      alu_result = 32'd0;
      case (ALUControlE)
         3'b000:  alu_result = src_a + src_b;
         3'b001:  alu_result = src_a - src_b;
         3'b010:  alu_result = src_a & src_b;
         3'b011:  alu_result = src_a | src_b;
         3'b101:  alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
         default: alu_result = 32'd0;
      endcase
   end

   assign zero      = (alu_result == 32'd0);
   assign PCSrcE    = BranchE & zero;
   assign PCTargetE = PCE + Imm_ExtE;

   always_comb begin
      reg_write_d  = RegWriteE;
      mem_write_d  = MemWriteE;
      result_src_d = ResultSrcE;
      rd_d         = RD_E;
      alu_result_d = alu_result;
      write_data_d = fwd_b;
      pc_plus4_d   = PCPlus4E;
      if (FlushM) begin
         reg_write_d  = 1'b0;
         mem_write_d  = 1'b0;
         result_src_d = 1'b0;
         rd_d         = 5'd0;
         alu_result_d = 32'd0;
         write_data_d = 32'd0;
         pc_plus4_d   = 32'd0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_write_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         result_src_q <= 1'b0;
         rd_q         <= 5'd0;
         alu_result_q <= 32'd0;
         write_data_q <= 32'd0;
         pc_plus4_q   <= 32'd0;
      end else begin
         reg_write_q  <= reg_write_d;
         mem_write_q  <= mem_write_d;
         result_src_q <= result_src_d;
         rd_q         <= rd_d;
         alu_result_q <= alu_result_d;
         write_data_q <= write_data_d;
         pc_plus4_q   <= pc_plus4_d;
      end
   end

   assign RegWriteM  = reg_write_q;
   assign MemWriteM  = mem_write_q;
   assign ResultSrcM = result_src_q;
   assign RD_M       = rd_q;
   assign ALUResultM = alu_result_q;
   assign WriteDataM = write_data_q;
   assign PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Scoreboard bench for execute_cycle: stimulus pushes expected M-stage contents,
// a monitor pops and compares after every rising edge.
module tb_execute_cycle;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1_E, RD2_E, Imm_ExtE, PCE, PCPlus4E, ResultW;
   logic [4:0]  RD_E;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        FlushM;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        RegWriteM, MemWriteM, ResultSrcM;
   logic [4:0]  RD_M;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

   execute_cycle dut (
      .clk(clk), .rst(rst),
      .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
      .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_ExtE(Imm_ExtE), .PCE(PCE),
      .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ResultW(ResultW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .FlushM(FlushM),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .PCPlus4M(PCPlus4M)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rw;
      logic        mw;
      logic        rs;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [31:0] pc4;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] m_alu = 32'd0;   // model's view of ALUResultM currently visible

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      int sa, sb;
      sa = int'(a);
      sb = int'(b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd);
      if (sel == 2'd1) return ResultW;
      if (sel == 2'd2) return m_alu;
      return rd;
   endfunction

   task automatic clear_inputs();
      {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, FlushM} = '0;
      ALUControlE = 3'd0;
      {RD1_E, RD2_E, Imm_ExtE, PCE, PCPlus4E, ResultW} = '0;
      RD_E = 5'd0;
      ForwardAE = 2'd0;
      ForwardBE = 2'd0;
   endtask

   task automatic randomize_inputs();
      RegWriteE   = 1'($urandom);
      ALUSrcE     = 1'($urandom);
      MemWriteE   = 1'($urandom);
      ResultSrcE  = 1'($urandom);
      BranchE     = 1'($urandom);
      ALUControlE = 3'($urandom);
      RD1_E       = $urandom;
      RD2_E       = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
      Imm_ExtE    = $urandom;
      PCE         = $urandom;
      PCPlus4E    = $urandom;
      ResultW     = $urandom;
      RD_E        = 5'($urandom);
      ForwardAE   = 2'($urandom);
      ForwardBE   = 2'($urandom);
      FlushM      = ($urandom_range(0, 7) == 0);
   endtask

   // Call just after driving inputs on a falling edge; returns #2 after the next rising edge.
   task automatic issue();
      logic [31:0] a, b, sb, r;
      exp_t e;
      a  = fwd(ForwardAE, RD1_E);
      b  = fwd(ForwardBE, RD2_E);
      sb = ALUSrcE ? Imm_ExtE : b;
      r  = model_alu(ALUControlE, a, sb);
      if (FlushM) e = '0;
      else e = '{rw: RegWriteE, mw: MemWriteE, rs: ResultSrcE, rd: RD_E, alu: r, wd: b,
                 pc4: PCPlus4E};
      exp_q.push_back(e);
      #1;
      check("PCSrcE", 32'(PCSrcE), 32'(BranchE && (r == 32'd0)));
      check("PCTargetE", PCTargetE, PCE + Imm_ExtE);
      m_alu = e.alu;
      @(posedge clk);
      #2;
   endtask

   task automatic check_m_zero(input string tag);
      check({tag, " RegWriteM"}, 32'(RegWriteM), 32'd0);
      check({tag, " MemWriteM"}, 32'(MemWriteM), 32'd0);
      check({tag, " ResultSrcM"}, 32'(ResultSrcM), 32'd0);
      check({tag, " RD_M"}, 32'(RD_M), 32'd0);
      check({tag, " ALUResultM"}, ALUResultM, 32'd0);
      check({tag, " WriteDataM"}, WriteDataM, 32'd0);
      check({tag, " PCPlus4M"}, PCPlus4M, 32'd0);
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("sb RegWriteM", 32'(RegWriteM), 32'(e.rw));
         check("sb MemWriteM", 32'(MemWriteM), 32'(e.mw));
         check("sb ResultSrcM", 32'(ResultSrcM), 32'(e.rs));
         check("sb RD_M", 32'(RD_M), 32'(e.rd));
         check("sb ALUResultM", ALUResultM, e.alu);
         check("sb WriteDataM", WriteDataM, e.wd);
         check("sb PCPlus4M", PCPlus4M, e.pc4);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      randomize_inputs();
      FlushM = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_m_zero("reset");

      // Reset release, first edge captures.
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      RD1_E = 32'd5; RD2_E = 32'd7; RD_E = 5'd3; RegWriteE = 1'b1;
      issue();
      check("rel ALUResultM", ALUResultM, 32'd12);
      check("rel RD_M", 32'(RD_M), 32'd3);
      check("rel RegWriteM", 32'(RegWriteM), 32'd1);

      // ALU operations.
      @(negedge clk); clear_inputs();
      RD1_E = 32'd5; RD2_E = 32'd7; ALUControlE = 3'b001; issue();
      check("sub", ALUResultM, 32'hFFFF_FFFE);
      @(negedge clk); clear_inputs();
      RD1_E = 32'hF0; RD2_E = 32'h3C; ALUControlE = 3'b010; issue();
      check("and", ALUResultM, 32'h30);
      @(negedge clk); clear_inputs();
      RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1; ALUControlE = 3'b101; issue();
      check("slt -1<1", ALUResultM, 32'd1);
      @(negedge clk); clear_inputs();
      RD1_E = 32'd1; RD2_E = 32'hFFFF_FFFF; ALUControlE = 3'b101; issue();
      check("slt 1<-1", ALUResultM, 32'd0);
      @(negedge clk); clear_inputs();
      RD1_E = 32'h1234; RD2_E = 32'h77; ALUControlE = 3'b111; issue();
      check("op111", ALUResultM, 32'd0);

      // Immediate operand with wrap.
      @(negedge clk); clear_inputs();
      ALUSrcE = 1'b1; RD1_E = 32'hFFFF_FFFF; Imm_ExtE = 32'd1; issue();
      check("imm wrap", ALUResultM, 32'd0);

      // Branch taken / not taken, checked combinationally.
      @(negedge clk); clear_inputs();
      BranchE = 1'b1; RD1_E = 32'd9; RD2_E = 32'd9; ALUControlE = 3'b001;
      PCE = 32'h100; Imm_ExtE = 32'hFFFF_FFF8;
      #1;
      check("beq taken", 32'(PCSrcE), 32'd1);
      check("beq target", PCTargetE, 32'hF8);
      issue();
      @(negedge clk);
      RD2_E = 32'd8;
      #1;
      check("beq not taken", 32'(PCSrcE), 32'd0);
      issue();

      // Forwarding from M and from W.
      @(negedge clk); clear_inputs();
      RD1_E = 32'd2; RD2_E = 32'd3; issue();
      @(negedge clk); clear_inputs();
      ForwardAE = 2'b10; RD1_E = 32'hDEAD; RD2_E = 32'd10; issue();
      check("fwd M", ALUResultM, 32'd15);
      @(negedge clk); clear_inputs();
      ForwardBE = 2'b01; ResultW = 32'h55; RD2_E = 32'h99; issue();
      check("fwd W", WriteDataM, 32'h55);

      // Flush.
      @(negedge clk); clear_inputs();
      MemWriteE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd7; RD1_E = 32'd4; FlushM = 1'b1;
      issue();
      check_m_zero("flush");

      for (int i = 0; i < 150; i++) begin
         @(negedge clk); randomize_inputs(); issue();
      end

      // Asynchronous reset in the middle of a cycle.
      @(negedge clk); clear_inputs();
      RD1_E = 32'd1; RD2_E = 32'd2; RegWriteE = 1'b1; RD_E = 5'd9; PCPlus4E = 32'h44;
      issue();
      rst = 1'b0;
      #1;
      check_m_zero("async rst");
      m_alu = 32'd0;
      PCE = 32'h200; Imm_ExtE = 32'h10;
      #1;
      check("rst PCTargetE", PCTargetE, 32'h210);
      repeat (2) @(posedge clk);
      #2;
      check_m_zero("held rst");
      @(negedge clk);
      rst = 1'b1;
      randomize_inputs();
      issue();

      for (int i = 0; i < 150; i++) begin
         @(negedge clk); randomize_inputs(); issue();
      end

      check("queue drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 SHALL have a single clock and an asynchronous active-low reset; no other clock or reset port.
REQ-002 clk  in  1  pipeline clock, all state updates on rising edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  in  1 each  control bits from the decode/execute register.
REQ-005 ALUControlE  in  3  ALU operation select.
REQ-006 RD1_E, RD2_E, Imm_ExtE, PCE, PCPlus4E  in  32 each  operands, immediate and PC values from decode.
REQ-007 RD_E  in  5  destination register index.
REQ-008 ResultW  in  32  writeback result, used for forwarding.
REQ-009 ForwardAE, ForwardBE  in  2 each  forwarding selects from the hazard unit.
REQ-010 FlushM  in  1  synchronous bubble insert into the execute/memory register.
REQ-011 PCSrcE  out  1  branch taken, combinational.
REQ-012 PCTargetE  out  32  branch target, combinational.
REQ-013 RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered control bits.
REQ-014 RD_M  out  5  registered destination index.
REQ-015 ALUResultM, WriteDataM, PCPlus4M  out  32 each  registered datapath values.

Function
REQ-016 SrcA SHALL be selected by ForwardAE: 00 RD1_E, 01 ResultW, 10 ALUResultM, 11 RD1_E.
REQ-017 The forwarded B value SHALL be selected the same way from RD2_E via ForwardBE; this value SHALL become WriteDataM.
REQ-018 SrcB SHALL equal Imm_ExtE when ALUSrcE=1, else the forwarded B value.
REQ-019 The ALU SHALL implement ALUControlE: 000 add, 001 sub, 010 and, 011 or, 101 signed set-less-than (result 1 or 0).
REQ-020 Codes 100, 110 and 111 SHALL produce a result of 0.
REQ-021 Add and sub SHALL wrap modulo 2^32; no overflow flag.
REQ-022 ZeroE SHALL be 1 when the 32-bit ALU result equals 0.
REQ-023 PCSrcE SHALL equal BranchE AND ZeroE, combinationally in the same cycle (beq semantics).
REQ-024 PCTargetE SHALL equal PCE + Imm_ExtE mod 2^32, combinationally.
REQ-025 The execute/memory register SHALL capture RegWriteE, MemWriteE, ResultSrcE, RD_E, the ALU result, the forwarded B value and PCPlus4E on each rising edge; latency is exactly 1 cycle.
REQ-026 When FlushM=1 at a rising edge, the register SHALL load RegWriteM=0, MemWriteM=0, ResultSrcM=0, RD_M=0; the data fields SHALL load 0.
REQ-027 Forward select 10 SHALL use the pre-edge ALUResultM value, i.e. the previous instruction's result, with no combinational loop.
REQ-028 A write to index 0 SHALL pass through unchanged; suppressing it is the register file's job.

Reset
REQ-029 While rst=0, all registered outputs SHALL be 0, independent of clk.
REQ-030 Reset asserted mid-operation SHALL clear the register immediately.
REQ-031 The first rising edge after rst returns to 1 SHALL capture normal inputs.
REQ-032 PCSrcE and PCTargetE SHALL stay combinational during reset.

Verification
REQ-033 Reset test: rst=0 with arbitrary inputs -> all M outputs 0; release, RD1_E=5, RD2_E=7, ALUControlE=000, RD_E=3, RegWriteE=1, then edge -> ALUResultM=12, RD_M=3, RegWriteM=1.
REQ-034 ALU ops test: 5 sub 7 -> 0xFFFFFFFE; 0xF0 and 0x3C -> 0x30; slt of -1 vs 1 -> 1; slt of 1 vs -1 -> 0; ALUControlE=111 -> 0.
REQ-035 Immediate and wrap test: ALUSrcE=1, RD1_E=0xFFFFFFFF, Imm_ExtE=1, add -> ALUResultM=0 after 1 cycle.
REQ-036 Branch test: BranchE=1, RD1_E=RD2_E=9, sub, PCE=0x100, Imm_ExtE=0xFFFFFFF8 -> PCSrcE=1 and PCTargetE=0xF8 in the same cycle; with RD2_E=8 -> PCSrcE=0.
REQ-037 Forwarding test: back-to-back add with ForwardAE=10 uses the prior ALUResultM; ForwardBE=01 with ResultW=0x55 -> WriteDataM=0x55 after the edge.
REQ-038 Flush test: MemWriteE=1 and RegWriteE=1 with FlushM=1 -> next cycle MemWriteM=0, RegWriteM=0, RD_M=0.
